// File: rtl/a78_loader.sv
// A78 cartridge image loader: strips an optional 128-byte header, rebases ROM
// data to address 0 and latches the cart descriptor fields at end of download.
module a78_loader #(
  parameter int MAX_AW = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic              mem_busy,
  output logic              wr_en,
  output logic [MAX_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              loading,
  output logic              header_present,
  output logic [9:0]        cart_flags,
  output logic [31:0]       cart_size,
  output logic              cart_region,
  output logic              overflow
);

  typedef enum logic [2:0] {IDLE, SIG, HDR, DATA, RAW} state_t;

  localparam logic [31:0] CAP32 = 32'd1 << MAX_AW;
  localparam logic [24:0] CAP25 = CAP32[24:0];

  state_t state_q, state_d;

  logic              dlPrev_q;
  logic              loading_q;
  logic [24:0]       ofs_q;
  logic              wrEn_q;
  logic [MAX_AW-1:0] wrAddr_q;
  logic [7:0]        wrData_q;
  logic              overflow_q;
  logic              hdrPresent_q;
  logic [9:0]        cartFlags_q;
  logic [31:0]       cartSize_q;
  logic              cartRegion_q;
  logic [31:0]       shSize_q;
  logic [9:0]        shFlags_q;
  logic              shRegion_q;

  logic        dlRise, dlFall, accept, violation, sigMatch;
  logic        doWrite, dropCap;
  logic [24:0] romAddr;
  logic [31:0] finalSize;
  logic [7:0]  sigChar;

  function automatic logic [31:0] clampCap(input logic [31:0] v);
    return (v > CAP32) ? CAP32 : v;
  endfunction

  assign dlRise    = ioctl_download & ~dlPrev_q;
  assign dlFall    = ~ioctl_download & dlPrev_q & (state_q != IDLE);
  assign accept    = ioctl_wr & ~wrEn_q & loading_q;
  assign violation = ioctl_wr & wrEn_q;
  assign sigMatch  = (ioctl_dout == sigChar);

  always_comb begin
    case (ofs_q[3:0])
      4'd1, 4'd3: sigChar = 8'h41;
      4'd2:       sigChar = 8'h54;
      4'd4:       sigChar = 8'h52;
      4'd5:       sigChar = 8'h49;
      4'd6:       sigChar = 8'h37;
      4'd7:       sigChar = 8'h38;
      4'd8, 4'd9: sigChar = 8'h30;
      default:    sigChar = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (dlRise) state_d = SIG;
      SIG: begin
        if (accept && ofs_q != 25'd0) begin
          if (!sigMatch)            state_d = RAW;
          else if (ofs_q == 25'd9)  state_d = HDR;
        end
      end
      HDR:     if (accept && ofs_q == 25'd127) state_d = DATA;
      default: state_d = state_q;
    endcase
    if (dlFall) state_d = IDLE;
  end

  // Byte routing, capacity check and the end-of-load size selection.
  always_comb begin
    romAddr   = (state_q == DATA) ? (ofs_q - 25'd128) : ofs_q;
    doWrite   = 1'b0;
    dropCap   = 1'b0;
    finalSize = 32'd0;
    if (accept && (state_q == SIG || state_q == DATA || state_q == RAW)) begin
      doWrite = (romAddr < CAP25);
      dropCap = ~doWrite;
    end
    case (state_q)
      DATA: begin
        if (shSize_q != 32'd0 && shSize_q <= CAP32) finalSize = shSize_q;
        else finalSize = clampCap({7'd0, ofs_q} - 32'd128);
      end
      RAW, SIG: finalSize = clampCap({7'd0, ofs_q});
      default:  finalSize = 32'd0;
    endcase
    ioctl_wait     = wrEn_q;
    wr_en          = wrEn_q;
    wr_addr        = wrAddr_q;
    wr_data        = wrData_q;
    loading        = loading_q;
    header_present = hdrPresent_q;
    cart_flags     = cartFlags_q;
    cart_size      = cartSize_q;
    cart_region    = cartRegion_q;
    overflow       = overflow_q;
  end

  // dlPrev_q resets high so a download already in progress is ignored until it rises again.
  always_ff @(posedge clk) begin
    if (reset) begin
      dlPrev_q     <= 1'b1;
      loading_q    <= 1'b0;
      ofs_q        <= '0;
      wrEn_q       <= 1'b0;
      wrAddr_q     <= '0;
      wrData_q     <= '0;
      overflow_q   <= 1'b0;
      hdrPresent_q <= 1'b0;
      cartFlags_q  <= '0;
      cartSize_q   <= '0;
      cartRegion_q <= 1'b0;
      shSize_q     <= '0;
      shFlags_q    <= '0;
      shRegion_q   <= 1'b0;
    end else begin
      dlPrev_q <= ioctl_download;
      if (dlRise && state_q == IDLE) begin
        loading_q  <= 1'b1;
        ofs_q      <= '0;
        overflow_q <= 1'b0;
        shSize_q   <= '0;
        shFlags_q  <= '0;
        shRegion_q <= 1'b0;
      end
      if (accept) begin
        ofs_q <= ofs_q + 25'd1;
        if (state_q == HDR) begin
          if (ofs_q >= 25'd49 && ofs_q <= 25'd52) shSize_q <= {shSize_q[23:0], ioctl_dout};
          if (ofs_q == 25'd53) shFlags_q[9:8] <= ioctl_dout[1:0];
          if (ofs_q == 25'd54) shFlags_q[7:0] <= ioctl_dout;
          if (ofs_q == 25'd57) shRegion_q     <= ioctl_dout[0];
        end
      end
      if (violation || dropCap) overflow_q <= 1'b1;
      if (doWrite) begin
        wrEn_q   <= 1'b1;
        wrAddr_q <= romAddr[MAX_AW-1:0];
        wrData_q <= ioctl_dout;
      end else if (wrEn_q && !mem_busy) begin
        wrEn_q <= 1'b0;
      end
      if (dlFall) begin
        loading_q    <= 1'b0;
        hdrPresent_q <= (state_q == HDR) || (state_q == DATA);
        cartFlags_q  <= shFlags_q;
        cartRegion_q <= shRegion_q;
        cartSize_q   <= finalSize;
      end
    end
  end

endmodule

// File: tb/tb_a78_loader.sv
// Scoreboard bench for a78_loader: drivers queue the expected ROM writes and a
// monitor pops and compares them whenever the store accepts a write.
module tb_a78_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [7:0]    ioctl_dout = 8'h00;
  logic          ioctl_wait;
  logic          mem_busy = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          loading;
  logic          header_present;
  logic [9:0]    cart_flags;
  logic [31:0]   cart_size;
  logic          cart_region;
  logic          overflow;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t expQ[$];
  int  assertCount = 0;
  int  failCount = 0;

  a78_loader #(.MAX_AW(AW)) dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_busy(mem_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .loading(loading),
    .header_present(header_present), .cart_flags(cart_flags), .cart_size(cart_size),
    .cart_region(cart_region), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: a write completes on an edge where wr_en is high and mem_busy is low.
  always @(negedge clk) begin
    wr_t w;
    if (wr_en && !mem_busy) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected write: addr 0x%0h data 0x%0h, expected none", wr_addr, wr_data);
      end else begin
        w = expQ.pop_front();
        checkOutput("write addr", 32'(wr_addr), 32'(w.addr));
        checkOutput("write data", 32'(wr_data), 32'(w.data));
      end
    end
  end

  function automatic logic [7:0] dataByte(input int i);
    return 8'((i * 13 + 7) ^ (i >> 8));
  endfunction

  task automatic waitReady();
    int guard = 0;
    while (ioctl_wait && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("ioctl_wait timeout", 32'(ioctl_wait), 32'd0);
  endtask

  // Issues one byte; when expectWrite is set the write it must produce is queued.
  task automatic applyStimulus(input logic [7:0] b, input bit expectWrite, input int addr);
    wr_t w;
    waitReady();
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    if (expectWrite) begin
      w.addr = addr[AW-1:0];
      w.data = b;
      expQ.push_back(w);
    end
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic startLoad();
    ioctl_download = 1'b1;
    @(posedge clk); #1;
    checkOutput("loading after rise", 32'(loading), 32'd1);
  endtask

  task automatic endLoad();
    ioctl_download = 1'b0;
    @(posedge clk); #1;
    checkOutput("loading after fall", 32'(loading), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
  endtask

  task automatic sendHeader(input logic [31:0] size, input logic [7:0] b53, input logic [7:0] b54, input logic [7:0] b57);
    logic [71:0] sig;
    logic [7:0]  b;
    sig = "ATARI7800";
    for (int i = 0; i < 128; i++) begin
      b = 8'h00;
      if (i == 0) b = 8'h03;
      else if (i <= 9) b = sig[8*(9-i) +: 8];
      else if (i >= 49 && i <= 52) b = size[8*(52-i) +: 8];
      else if (i == 53) b = b53;
      else if (i == 54) b = b54;
      else if (i == 57) b = b57;
      applyStimulus(b, i < 10, i);
    end
  endtask

  task automatic sendData(input int n);
    for (int i = 0; i < n; i++) applyStimulus(dataByte(i), 1'b1, i);
  endtask

  task automatic violationPulse();
    checkOutput("wait high before violation", 32'(ioctl_wait), 32'd1);
    ioctl_dout = 8'hEE;
    ioctl_wr   = 1'b1;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    checkOutput("overflow after violation", 32'(overflow), 32'd1);
  endtask

  task automatic stallByte(input logic [7:0] b, input int addr);
    wr_t w;
    waitReady();
    w.addr = addr[AW-1:0];
    w.data = b;
    expQ.push_back(w);
    ioctl_dout = b;
    ioctl_wr   = 1'b1;
    mem_busy   = 1'b1;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) mem_busy = 1'b0;
      checkOutput("stall wr_en", 32'(wr_en), 32'd1);
      checkOutput("stall wait", 32'(ioctl_wait), 32'd1);
      checkOutput("stall addr", 32'(wr_addr), 32'(addr));
      checkOutput("stall data", 32'(wr_data), 32'(b));
      if (k < 5) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    checkOutput("wr_en after stall", 32'(wr_en), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("reset wr_en", 32'(wr_en), 32'd0);
    checkOutput("reset loading", 32'(loading), 32'd0);
    checkOutput("reset cart_size", cart_size, 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);

    $display("[TB] headered image, size field 0x200");
    startLoad();
    sendHeader(32'h0000_0200, 8'h00, 8'h02, 8'h01);
    checkOutput("header_present held mid-load", 32'(header_present), 32'd0);
    sendData(300);
    endLoad();
    checkOutput("hdr1 header_present", 32'(header_present), 32'd1);
    checkOutput("hdr1 cart_size", cart_size, 32'h200);
    checkOutput("hdr1 cart_flags", 32'(cart_flags), 32'h002);
    checkOutput("hdr1 cart_region", 32'(cart_region), 32'd1);
    checkOutput("hdr1 overflow", 32'(overflow), 32'd0);

    $display("[TB] headered image, size field zero");
    startLoad();
    sendHeader(32'h0, 8'h03, 8'h45, 8'h00);
    checkOutput("cart_size held mid-load", cart_size, 32'h200);
    sendData(200);
    endLoad();
    checkOutput("hdr2 cart_size", cart_size, 32'd200);
    checkOutput("hdr2 cart_flags", 32'(cart_flags), 32'h345);
    checkOutput("hdr2 cart_region", 32'(cart_region), 32'd0);

    $display("[TB] reset in DATA");
    startLoad();
    sendHeader(32'h0000_0100, 8'h00, 8'h01, 8'h01);
    for (int i = 0; i < 50; i++) begin
      applyStimulus(dataByte(i), 1'b1, i);
      if (i == 30) violationPulse();
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("rst wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst ioctl_wait", 32'(ioctl_wait), 32'd0);
    checkOutput("rst loading", 32'(loading), 32'd0);
    checkOutput("rst overflow", 32'(overflow), 32'd0);
    checkOutput("rst header_present", 32'(header_present), 32'd0);
    checkOutput("rst cart_flags", 32'(cart_flags), 32'd0);
    checkOutput("rst cart_size", cart_size, 32'd0);
    checkOutput("rst scoreboard empty", 32'(expQ.size()), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("high download ignored", 32'(loading), 32'd0);
    applyStimulus(8'h77, 1'b0, 0);
    ioctl_download = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("idle fall no latch", 32'(header_present), 32'd0);

    $display("[TB] fresh headered image, oversized size field");
    startLoad();
    sendHeader(32'h0000_1000, 8'h01, 8'h80, 8'h01);
    sendData(64);
    endLoad();
    checkOutput("hdr3 header_present", 32'(header_present), 32'd1);
    checkOutput("hdr3 cart_size", cart_size, 32'd64);
    checkOutput("hdr3 cart_flags", 32'(cart_flags), 32'h180);
    checkOutput("hdr3 cart_region", 32'(cart_region), 32'd1);

    $display("[TB] headerless image with stall and protocol violation");
    startLoad();
    for (int i = 0; i < 256; i++) begin
      if (i == 20) stallByte(dataByte(i), i);
      else applyStimulus((i == 1) ? 8'h00 : dataByte(i), 1'b1, i);
      if (i == 40) violationPulse();
    end
    endLoad();
    checkOutput("raw header_present", 32'(header_present), 32'd0);
    checkOutput("raw cart_size", cart_size, 32'd256);
    checkOutput("raw cart_flags", 32'(cart_flags), 32'd0);
    checkOutput("raw cart_region", 32'(cart_region), 32'd0);
    checkOutput("raw overflow", 32'(overflow), 32'd1);

    $display("[TB] capacity overflow, one byte past 2^AW");
    startLoad();
    for (int i = 0; i < 1024; i++) applyStimulus((i == 1) ? 8'h11 : dataByte(i), 1'b1, i);
    checkOutput("cap overflow before last", 32'(overflow), 32'd0);
    applyStimulus(8'hA5, 1'b0, 0);
    endLoad();
    checkOutput("cap overflow", 32'(overflow), 32'd1);
    checkOutput("cap cart_size", cart_size, 32'h400);
    checkOutput("cap header_present", 32'(header_present), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/a78_loader.md
# a78_loader

Cartridge image loader that writes downloaded ROM bytes into the cartridge ROM store read by the 7800 core via `cart_addr_out`/`cart_out`. It is the writer side of that interface. It parses an optional 128-byte A78 header, strips it, and rebases ROM data to address 0. It latches `cart_flags`, `cart_size` and `cart_region` for the cart mapper. It sits between the HPS download stream (`ioctl_*`) and the ROM store write port, and runs on the system clock.

## Interface
- `MAX_AW`, default 18: ROM store address width. Capacity is 2^MAX_AW bytes.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high. Forces every register to its reset value.
- `ioctl_download`, input, 1: high for the duration of an image download.
- `ioctl_wr`, input, 1: single-cycle strobe that qualifies `ioctl_dout`.
- `ioctl_dout`, input, 8: download byte.
- `ioctl_wait`, output, 1: upstream must not strobe `ioctl_wr` while this is high.
- `mem_busy`, input, 1: ROM store cannot accept a write this cycle.
- `wr_en`, output, 1: ROM store write request. Held until accepted.
- `wr_addr`, output, MAX_AW: ROM store byte address.
- `wr_data`, output, 8: ROM store write data.
- `loading`, output, 1: a download is in progress.
- `header_present`, output, 1: the last image carried a valid A78 header.
- `cart_flags`, output, 10: cart type, `{byte53[1:0], byte54}`.
- `cart_size`, output, 32: ROM byte count after the header is stripped.
- `cart_region`, output, 1: header byte 57 bit 0 (1 = PAL).
- `overflow`, output, 1: sticky error. Set on a byte past capacity or an `ioctl_wr` received while `ioctl_wait` is high.

## Operation
- Byte counter `ofs` (25 bits) counts accepted bytes from 0. `ioctl_addr` is not used.
- State `IDLE`:
  - A rising edge of `ioctl_download` clears `ofs`, the `overflow` flag and the shadow fields.
  - It sets `loading` and enters `SIG`.
- State `SIG`, `ofs` 0..9:
  - Every byte is written to ROM at `ofs`.
  - Bytes 1..9 are compared with ASCII "ATARI7800". Any mismatch enters `RAW`.
  - A full match on byte 9 enters `HDR`.
- State `HDR`, `ofs` 10..127:
  - No ROM writes.
  - Bytes 49..52 are captured big-endian into shadow size, 53..54 into shadow flags, and 57 into shadow region.
  - On `ofs` = 127 the block enters `DATA`.
- State `DATA`: each byte is written at `ofs - 128`. Bytes 0..9 already written by `SIG` are later overwritten by ROM data.
- State `RAW`: each byte is written at `ofs`. Shadow flags and region stay 0.
- Capacity limit: a byte whose ROM address is at or above 2^MAX_AW is dropped and sets `overflow`. `ofs` still advances.
- Falling edge of `ioctl_download`, from any state:
  - `loading` is cleared.
  - `header_present` is set to (final state was `HDR` or `DATA`).
  - `cart_flags` and `cart_region` take their shadow values.
  - `cart_size` is set by state:
    - `DATA`: the shadow size if it is nonzero and at most 2^MAX_AW, otherwise `ofs - 128`, clamped to 2^MAX_AW.
    - `RAW` or `SIG`: `ofs`, clamped to 2^MAX_AW.
    - `HDR`: 0.
  - The block returns to `IDLE`.
- Outputs `cart_*` and `header_present` hold their previous values throughout a download.

## Timing
- A byte is accepted on the cycle in which `ioctl_wr` is high and `ioctl_wait` is low. It is dropped if `loading` is low.
- `wr_en`, `wr_addr` and `wr_data` are registered and asserted on the cycle after acceptance.
- `wr_en` stays high, with stable address and data, until a cycle with `mem_busy` low. It deasserts on the following edge.
- `ioctl_wait` is high from the cycle after acceptance until `wr_en` deasserts.
- Bytes that produce no write (`HDR` bytes, dropped bytes) do not raise `ioctl_wait`.
- Throughput: 1 byte every 2 cycles with `mem_busy` low.
- `ioctl_wr` while `ioctl_wait` is high: the byte is discarded, `ofs` does not advance, and `overflow` is set.
- Falling edge of `ioctl_download` while a write is pending:
  - The pending write completes.
  - The end-of-load latch happens on the same edge.
  - `loading` drops immediately.
- `reset` mid-download:
  - Next cycle: `wr_en`, `ioctl_wait`, `loading`, `overflow` and `header_present` are 0; `cart_flags`, `cart_size` and `cart_region` are 0.
  - State is `IDLE`.
  - A still-high `ioctl_download` is ignored until it next rises.

## Test plan
- **Headered image:**
  - Stimulus: 128-byte header with "ATARI7800", size bytes 00 00 C0 00, type bytes 00 02, byte 57 = 01, then 48 KiB of data.
  - Required: first data byte written at `wr_addr` 0; no writes for `ofs` 10..127; `header_present`=1, `cart_size`=0xC000, `cart_flags`=0x002, `cart_region`=1.
- **Headerless image:**
  - Stimulus: 32 KiB image whose byte 1 is 0x00.
  - Required: `RAW`; 32768 writes at `wr_addr` = `ofs`; `cart_size`=0x8000, `header_present`=0, `cart_flags`=0.
- **`mem_busy` stall:**
  - Stimulus: `mem_busy` held high for 5 cycles on a write.
  - Required: `wr_en`, address and data stable for 6 cycles; `ioctl_wait` high throughout; no byte lost.
- **Protocol violation:**
  - Stimulus: `ioctl_wr` pulsed while `ioctl_wait` is high.
  - Required: byte discarded, `ofs` unchanged, `overflow`=1.
- **Capacity overflow:**
  - Stimulus: MAX_AW=18, headerless image of 262145 bytes.
  - Required: last byte not written, `overflow`=1, `cart_size`=0x40000.
- **Reset mid-`DATA`:**
  - Required: all outputs 0 next cycle; a fresh download afterwards parses correctly.
